// File: rtl/frame_renderer.sv
// frame_renderer: VGA-style raster with 2-stage tile/sprite/heart colour pipeline.
// Optional seconds bar is built only when RENDERER_SECONDS_BAR_EN is defined.
module frame_renderer #(
  parameter int SCREEN_WIDTH    = 640,
  parameter int SCREEN_HEIGHT   = 480,
  parameter int BLOCK_WIDTH     = 40,
  parameter int CHARACTER_WIDTH = 42,
  parameter int H_FRONT         = 16,
  parameter int H_SYNC          = 96,
  parameter int H_BACK          = 48,
  parameter int V_FRONT         = 10,
  parameter int V_SYNC          = 2,
  parameter int V_BACK          = 33
) (
  input  logic                     vga_clock,
  input  logic                     reset,
  input  logic [11:0][16:0][7:0]   background,
  input  logic signed [31:0]       mario_x,
  input  logic signed [31:0]       mario_y,
  input  logic signed [31:0]       goomba_x,
  input  logic signed [31:0]       goomba_y,
  input  logic signed [31:0]       goomba_2x,
  input  logic signed [31:0]       goomba_2y,
  input  logic                     show_hearts,
  input  logic signed [31:0]       lives,
  input  logic signed [31:0]       seconds,
  output logic                     hsync,
  output logic                     vsync,
  output logic                     active,
  output logic [11:0]              rgb,
  output logic                     frame_start
);

  localparam logic [9:0] H_ACT    = 10'(SCREEN_WIDTH);
  localparam logic [9:0] V_ACT    = 10'(SCREEN_HEIGHT);
  localparam logic [9:0] HS_FIRST = 10'(SCREEN_WIDTH + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(SCREEN_WIDTH + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] H_LAST   = 10'(SCREEN_WIDTH + H_FRONT + H_SYNC + H_BACK - 1);
  localparam logic [9:0] VS_FIRST = 10'(SCREEN_HEIGHT + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(SCREEN_HEIGHT + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] V_LAST   = 10'(SCREEN_HEIGHT + V_FRONT + V_SYNC + V_BACK - 1);
  localparam logic [9:0] BW       = 10'(BLOCK_WIDTH);
  localparam logic signed [32:0] CW        = 33'(CHARACTER_WIDTH);
  localparam logic signed [31:0] OFFSCREEN = 32'sd1000;

  typedef struct packed {
    logic signed [31:0] mx;
    logic signed [31:0] my;
    logic signed [31:0] gx;
    logic signed [31:0] gy;
    logic signed [31:0] g2x;
    logic signed [31:0] g2y;
  } sprite_pos_t;

  logic [9:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
  logic        end_of_frame;
  sprite_pos_t pos_q, pos_d;
  logic        show_hearts_q, show_hearts_d;
  logic [2:0]  hearts_n_q, hearts_n_d;

  logic        raw_active;
  logic [3:0]  row_idx;
  logic [4:0]  col_idx;
  logic        heart_hit;

  logic        s1_active_q, s1_active_d, s1_hsync_q, s1_hsync_d, s1_vsync_q, s1_vsync_d;
  logic        s1_first_q, s1_first_d, s1_mario_q, s1_mario_d, s1_goomba_q, s1_goomba_d;
  logic        s1_heart_q, s1_heart_d;
  logic [7:0]  s1_tile_q, s1_tile_d;

  logic [11:0] tile_rgb, rgb_q, rgb_d;
  logic        hsync_q, vsync_q, active_q, frame_start_q;

`ifdef RENDERER_SECONDS_BAR_EN
  logic [9:0]  bar_len_q, bar_len_d;
  logic        s1_bar_q, s1_bar_d;
  localparam logic [9:0] BAR_Y0 = 10'(SCREEN_HEIGHT - 20);
  localparam logic [9:0] BAR_Y1 = 10'(SCREEN_HEIGHT - 9);
`else
  logic unused_seconds;
  assign unused_seconds = ^seconds;
`endif

  // 33-bit signed compare so positions near the int limits cannot wrap into view
  function automatic logic sprite_hit(input logic signed [31:0] sx, input logic signed [31:0] sy,
                                      input logic [9:0] h, input logic [9:0] v);
    logic signed [32:0] x0, y0, hp, vp;
    x0 = {sx[31], sx};
    y0 = {sy[31], sy};
    hp = $signed({23'd0, h});
    vp = $signed({23'd0, v});
    return (x0 <= hp) && (hp < x0 + CW) && (y0 <= vp) && (vp < y0 + CW);
  endfunction

  always_comb begin
    end_of_frame  = (h_cnt_q == H_LAST) && (v_cnt_q == V_LAST);
    h_cnt_d       = h_cnt_q + 10'd1;
    v_cnt_d       = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? 10'd0 : v_cnt_q + 10'd1;
    end
    pos_d         = pos_q;
    show_hearts_d = show_hearts_q;
    hearts_n_d    = hearts_n_q;
`ifdef RENDERER_SECONDS_BAR_EN
    bar_len_d     = bar_len_q;
`endif
    if (end_of_frame) begin
      pos_d         = '{mario_x, mario_y, goomba_x, goomba_y, goomba_2x, goomba_2y};
      show_hearts_d = show_hearts;
      if (lives <= 0)      hearts_n_d = 3'd0;
      else if (lives >= 5) hearts_n_d = 3'd5;
      else                 hearts_n_d = lives[2:0];
`ifdef RENDERER_SECONDS_BAR_EN
      if (seconds <= 0)       bar_len_d = 10'd0;
      else if (seconds >= 99) bar_len_d = 10'd594;
      else                    bar_len_d = 10'(seconds[6:0]) * 10'd6;
`endif
    end
  end

  always_comb begin
    heart_hit = 1'b0;
    if (show_hearts_q && (v_cnt_q >= 10'd8) && (v_cnt_q <= 10'd23)) begin
      for (int i = 0; i < 5; i++) begin
        if ((3'(i) < hearts_n_q) && (h_cnt_q >= 10'(8 + 20 * i)) && (h_cnt_q <= 10'(23 + 20 * i)))
          heart_hit = 1'b1;
      end
    end
  end

  always_comb begin
    raw_active  = (h_cnt_q < H_ACT) && (v_cnt_q < V_ACT);
    // blanking coordinates would index past the tile map, so park them on tile (0,0)
    row_idx     = raw_active ? 4'(v_cnt_q / BW) : 4'd0;
    col_idx     = raw_active ? 5'(h_cnt_q / BW) : 5'd0;
    s1_active_d = raw_active;
    s1_hsync_d  = !((h_cnt_q >= HS_FIRST) && (h_cnt_q <= HS_LAST));
    s1_vsync_d  = !((v_cnt_q >= VS_FIRST) && (v_cnt_q <= VS_LAST));
    s1_first_d  = (h_cnt_q == 10'd0) && (v_cnt_q == 10'd0);
    s1_tile_d   = background[row_idx][col_idx];
    s1_mario_d  = sprite_hit(pos_q.mx, pos_q.my, h_cnt_q, v_cnt_q);
    s1_goomba_d = sprite_hit(pos_q.gx, pos_q.gy, h_cnt_q, v_cnt_q) ||
                  sprite_hit(pos_q.g2x, pos_q.g2y, h_cnt_q, v_cnt_q);
    s1_heart_d  = heart_hit;
`ifdef RENDERER_SECONDS_BAR_EN
    s1_bar_d    = (v_cnt_q >= BAR_Y0) && (v_cnt_q <= BAR_Y1) && (h_cnt_q < bar_len_q);
`endif
  end

  always_comb begin
    case (s1_tile_q)
      8'd0:    tile_rgb = 12'h000;
      8'd1:    tile_rgb = 12'h5AF;
      8'd2:    tile_rgb = 12'hA52;
      8'd3:    tile_rgb = 12'h730;
      8'd4:    tile_rgb = 12'hFD0;
      8'd5:    tile_rgb = 12'hFFF;
      8'd6:    tile_rgb = 12'h000;
      default: tile_rgb = 12'hF0F;
    endcase
    // later assignments win: tile < bar < heart < goomba < mario
    rgb_d = tile_rgb;
`ifdef RENDERER_SECONDS_BAR_EN
    if (s1_bar_q)    rgb_d = 12'h0F0;
`endif
    if (s1_heart_q)  rgb_d = 12'hF00;
    if (s1_goomba_q) rgb_d = 12'h841;
    if (s1_mario_q)  rgb_d = 12'hE00;
    if (!s1_active_q) rgb_d = 12'h000;
  end

  always_ff @(posedge vga_clock) begin
    if (reset) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      pos_q         <= '{OFFSCREEN, OFFSCREEN, OFFSCREEN, OFFSCREEN, OFFSCREEN, OFFSCREEN};
      show_hearts_q <= 1'b0;
      hearts_n_q    <= 3'd0;
      s1_active_q   <= 1'b0;
      s1_hsync_q    <= 1'b1;
      s1_vsync_q    <= 1'b1;
      s1_first_q    <= 1'b0;
      s1_tile_q     <= 8'd0;
      s1_mario_q    <= 1'b0;
      s1_goomba_q   <= 1'b0;
      s1_heart_q    <= 1'b0;
      rgb_q         <= 12'h000;
      hsync_q       <= 1'b1;
      vsync_q       <= 1'b1;
      active_q      <= 1'b0;
      frame_start_q <= 1'b0;
`ifdef RENDERER_SECONDS_BAR_EN
      bar_len_q     <= 10'd0;
      s1_bar_q      <= 1'b0;
`endif
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      pos_q         <= pos_d;
      show_hearts_q <= show_hearts_d;
      hearts_n_q    <= hearts_n_d;
      s1_active_q   <= s1_active_d;
      s1_hsync_q    <= s1_hsync_d;
      s1_vsync_q    <= s1_vsync_d;
      s1_first_q    <= s1_first_d;
      s1_tile_q     <= s1_tile_d;
      s1_mario_q    <= s1_mario_d;
      s1_goomba_q   <= s1_goomba_d;
      s1_heart_q    <= s1_heart_d;
      rgb_q         <= rgb_d;
      hsync_q       <= s1_hsync_q;
      vsync_q       <= s1_vsync_q;
      active_q      <= s1_active_q;
      frame_start_q <= s1_first_q;
`ifdef RENDERER_SECONDS_BAR_EN
      bar_len_q     <= bar_len_d;
      s1_bar_q      <= s1_bar_d;
`endif
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign active      = active_q;
  assign rgb         = rgb_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_frame_renderer.sv
// Directed bench for frame_renderer on a shrunken raster (160x64 visible, 176x70 total)
// so several complete frames fit in a short run; geometry rules are unchanged.
module tb_frame_renderer;
  localparam int W = 160, H = 64, HT = 176, VT = 70, FRAME = HT * VT;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic [11:0][16:0][7:0] background;
  int   mario_x, mario_y, goomba_x, goomba_y, goomba_2x, goomba_2y;
  logic show_hearts;
  int   lives, seconds;
  logic hsync, vsync, active, frame_start;
  logic [11:0] rgb;

  int cyc = 0;
  int tests = 0, fails = 0;
  int hs_low = 0, vs_low = 0, hs_falls = 0, fs_cnt = 0;
  logic hs_prev = 1'b1;

  frame_renderer #(
    .SCREEN_WIDTH(W), .SCREEN_HEIGHT(H), .BLOCK_WIDTH(16), .CHARACTER_WIDTH(42),
    .H_FRONT(4), .H_SYNC(8), .H_BACK(4), .V_FRONT(2), .V_SYNC(2), .V_BACK(2)
  ) dut (
    .vga_clock(clk), .reset(reset), .background(background),
    .mario_x(mario_x), .mario_y(mario_y), .goomba_x(goomba_x), .goomba_y(goomba_y),
    .goomba_2x(goomba_2x), .goomba_2y(goomba_2y),
    .show_hearts(show_hearts), .lives(lives), .seconds(seconds),
    .hsync(hsync), .vsync(vsync), .active(active), .rgb(rgb), .frame_start(frame_start)
  );

  always @(posedge clk) cyc <= reset ? 0 : cyc + 1;

  always @(negedge clk) begin
    if (!reset && cyc >= 2 && cyc < FRAME + 2) begin
      if (!hsync) hs_low <= hs_low + 1;
      if (!vsync) vs_low <= vs_low + 1;
      if (hs_prev && !hsync) hs_falls <= hs_falls + 1;
      if (frame_start) fs_cnt <= fs_cnt + 1;
    end
    hs_prev <= hsync;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic at_cyc(input int n, input string tag);
    int guard = 0;
    while (cyc < n && guard < 200000) begin
      @(negedge clk);
      guard++;
    end
    #1;
    if (cyc != n) begin
      tests++;
      fails++;
      $display("FAIL %s sample point observed_cycle=%0d expected_cycle=%0d", tag, cyc, n);
    end
  endtask

  function automatic int px(input int f, input int x, input int y);
    return f * FRAME + y * HT + x + 2;
  endfunction

  task automatic chk_px(input string tag, input int f, input int x, input int y, input logic [11:0] exp);
    at_cyc(px(f, x, y), tag);
    chk(tag, 32'(rgb), 32'(exp));
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rgb"}, 32'(rgb), 32'h000);
    chk({tag, "_hsync"}, 32'(hsync), 32'd1);
    chk({tag, "_vsync"}, 32'(vsync), 32'd1);
    chk({tag, "_active"}, 32'(active), 32'd0);
    chk({tag, "_fs"}, 32'(frame_start), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  codes [8];
    logic [11:0] cols  [8];
    codes = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd200};
    cols  = '{12'h000, 12'h5AF, 12'hA52, 12'h730, 12'hFD0, 12'hFFF, 12'h000, 12'hF0F};

    for (int r = 0; r < 12; r++)
      for (int c = 0; c < 17; c++) background[r][c] = 8'd1;
    mario_x = 100;    mario_y = 20;
    goomba_x = 120;   goomba_y = 30;
    goomba_2x = -100; goomba_2y = -100;
    show_hearts = 1'b1; lives = 7; seconds = 10;

    repeat (3) @(negedge clk);
    #1;
    chk_reset_outputs("reset");
    @(negedge clk);
    reset = 1'b0;

    // frame 0: everything latched at reset values, all tiles code 1
    at_cyc(1, "pre_valid");
    chk("pre_valid_rgb", 32'(rgb), 32'h000);
    chk("pre_valid_active", 32'(active), 32'd0);
    chk_px("f0_px0_0", 0, 0, 0, 12'h5AF);
    chk("f0_fs_first", 32'(frame_start), 32'd1);
    chk("f0_active_first", 32'(active), 32'd1);
    at_cyc(px(0, 1, 0), "f0_fs_second");
    chk("f0_fs_second", 32'(frame_start), 32'd0);
    chk_px("f0_last_vis", 0, 159, 0, 12'h5AF);
    chk_px("f0_hblank", 0, 160, 0, 12'h000);
    chk("f0_hblank_active", 32'(active), 32'd0);
    at_cyc(px(0, 163, 0), "hs163"); chk("hs163", 32'(hsync), 32'd1);
    at_cyc(px(0, 164, 0), "hs164"); chk("hs164", 32'(hsync), 32'd0);
    at_cyc(px(0, 171, 0), "hs171"); chk("hs171", 32'(hsync), 32'd0);
    at_cyc(px(0, 172, 0), "hs172"); chk("hs172", 32'(hsync), 32'd1);
    chk_px("f0_mario_not_latched", 0, 100, 20, 12'h5AF);
    chk_px("f0_vblank", 0, 0, 64, 12'h000);
    chk("f0_vblank_active", 32'(active), 32'd0);
    at_cyc(px(0, 0, 65), "vs65");  chk("vs65", 32'(vsync), 32'd1);
    at_cyc(px(0, 0, 66), "vs66");  chk("vs66", 32'(vsync), 32'd0);
    at_cyc(px(0, 175, 67), "vs67"); chk("vs67", 32'(vsync), 32'd0);
    at_cyc(px(0, 0, 68), "vs68");  chk("vs68", 32'(vsync), 32'd1);
    for (int c = 0; c < 8; c++) background[3][c] = codes[c];

    // frame 1: sprites, hearts (lives 7 clamps to 5), tile colour map
    chk_px("f1_px0_0", 1, 0, 0, 12'h5AF);
    chk("f1_fs", 32'(frame_start), 32'd1);
    chk("frame_hs_low", 32'(hs_low), 32'd560);
    chk("frame_hs_falls", 32'(hs_falls), 32'd70);
    chk("frame_vs_low", 32'(vs_low), 32'd352);
    chk("frame_fs_count", 32'(fs_cnt), 32'd1);
    mario_x = 0; goomba_x = 1000; goomba_y = 1000; lives = 0; seconds = 150;
    chk_px("f1_heart0", 1, 8, 8, 12'hF00);
    chk_px("f1_heart_gap", 1, 24, 8, 12'h5AF);
    chk_px("f1_heart4", 1, 88, 8, 12'hF00);
    chk_px("f1_no_heart5", 1, 108, 8, 12'h5AF);
    chk_px("f1_mario_over_heart", 1, 100, 20, 12'hE00);
    chk_px("f1_heart0_corner", 1, 23, 23, 12'hF00);
    chk_px("f1_mario_right_out", 1, 142, 25, 12'h5AF);
    chk_px("f1_mario_left_out", 1, 99, 30, 12'h5AF);
    chk_px("f1_mario_over_goomba", 1, 130, 40, 12'hE00);
    chk_px("f1_mario_right_edge", 1, 141, 40, 12'hE00);
`ifdef RENDERER_SECONDS_BAR_EN
    chk_px("f1_bar_end", 1, 59, 45, 12'h0F0);
`else
    chk_px("f1_no_bar", 1, 59, 45, 12'h5AF);
`endif
    chk_px("f1_after_bar", 1, 60, 45, 12'h5AF);
    chk_px("f1_goomba", 1, 150, 62, 12'h841);
    for (int c = 0; c < 8; c++)
      chk_px($sformatf("f1_tile_code%0d", codes[c]), 1, 16 * c + 1, 63, cols[c]);

    // frame 2: values changed mid frame 1 take effect now
    chk_px("f2_lives0_no_heart", 2, 8, 8, 12'h5AF);
    chk_px("f2_mario_moved", 2, 0, 20, 12'hE00);
    chk_px("f2_mario_right_out", 2, 42, 20, 12'h5AF);
    chk_px("f2_old_mario_gone", 2, 100, 20, 12'h5AF);
    chk_px("f2_goomba_gone", 2, 130, 40, 12'h5AF);
`ifdef RENDERER_SECONDS_BAR_EN
    chk_px("f2_bar_clamped", 2, 159, 45, 12'h0F0);
`endif
    chk_px("f2_mario_corner", 2, 41, 61, 12'hE00);

    // mid-frame reset in frame 3
    at_cyc(px(3, 50, 30), "midframe_reset");
    reset = 1'b1;
    @(negedge clk);
    #1;
    chk_reset_outputs("mid_reset");
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    at_cyc(1, "restart_pre_valid");
    chk("restart_pre_valid_rgb", 32'(rgb), 32'h000);
    chk_px("restart_px0_0", 0, 0, 0, 12'h5AF);
    chk("restart_fs", 32'(frame_start), 32'd1);
    chk_px("restart_hearts_cleared", 0, 8, 8, 12'h5AF);
    chk_px("restart_mario_cleared", 0, 0, 20, 12'h5AF);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/frame_renderer.md
FRAME_RENDERER -- requirements
Module: frame_renderer

Interface
REQ-001 SHALL have parameter SCREEN_WIDTH, default 640: active pixels per line.
REQ-002 SHALL have parameter SCREEN_HEIGHT, default 480: active lines per frame.
REQ-003 SHALL have parameter BLOCK_WIDTH, default 40: tile edge in pixels.
REQ-004 SHALL have parameter CHARACTER_WIDTH, default 42: sprite edge in pixels.
REQ-005 SHALL have one clock and a synchronous, active-high reset: vga_clock  in  1  pixel clock; reset  in  1  synchronous active-high reset.
REQ-006 SHALL have port background  in  byte[11:0][16:0]  tile codes [row][col].
REQ-007 SHALL have ports mario_x, mario_y, goomba_x, goomba_y, goomba_2x, goomba_2y  in  int (signed 32)  sprite top-left pixel.
REQ-008 SHALL have ports show_hearts  in  1; lives  in  int; seconds  in  int.
REQ-009 SHALL have outputs hsync  out  1  active-low; vsync  out  1  active-low; active  out  1  visible pixel.
REQ-010 SHALL have outputs rgb  out  12  4:4:4 colour; frame_start  out  1  one-cycle pulse.

Function
REQ-011 SHALL run h_cnt 0..799 per line and v_cnt 0..524 per frame; h wraps 799->0 with v increment; v wraps 524->0.
REQ-012 SHALL form raw hsync low for h_cnt 656..751, raw vsync low for v_cnt 490..491, raw active for h<640 and v<480.
REQ-013 SHALL pipeline in 2 stages: stage 1 computes col=h/BLOCK_WIDTH, row=v/BLOCK_WIDTH, fetches background[row][col], evaluates sprite hits; stage 2 selects colour.
REQ-014 SHALL delay hsync, vsync, active by 2 cycles so they align with rgb; latency counter->rgb = 2 cycles.
REQ-015 SHALL output rgb=0x000 whenever delayed active=0.
REQ-016 SHALL map tile codes: 0->0x000, 1->0x5AF, 2->0xA52, 3->0x730, 4->0xFD0, 5->0xFFF, 6->0x000, any other->0xF0F.
REQ-017 SHALL treat a sprite as hit when sx<=h<sx+CHARACTER_WIDTH and sy<=v<sy+CHARACTER_WIDTH, signed 32-bit compare; negative or >=screen positions (e.g. 1000) SHALL produce no hit and no wrap.
REQ-018 SHALL apply priority mario (0xE00) > goomba (0x841) > goomba_2 (0x841) > heart (0xF00) > tile.
REQ-019 SHALL draw N=clamp(lives,0,5) hearts when show_hearts=1, heart i covering x 8+20i..8+20i+15, y 8..23; lives<=0 draws none.
REQ-020 SHALL latch all sprite positions, show_hearts, lives, seconds in the cycle h_cnt=799,v_cnt=524; latched values SHALL hold for the whole next frame; background SHALL be sampled live.
REQ-021 SHALL pulse frame_start high for one cycle, aligned with the delayed output of pixel (0,0).

Reset
REQ-022 SHALL, while reset=1 at a vga_clock edge, set h_cnt=v_cnt=0, pipeline stages cleared, rgb=0x000, hsync=1, vsync=1, active=0, frame_start=0.
REQ-023 SHALL set latched sprite positions to 1000, show_hearts=0, lives=0, seconds=0 on reset.
REQ-024 SHALL, when reset asserts mid-frame, abandon the frame; first cycle after release counts (0,0); first valid rgb 2 cycles later.

Configuration
REQ-025 SHALL, with RENDERER_SECONDS_BAR_EN defined, draw a bar colour 0x0F0 at y 460..471, x 0..6*clamp(seconds,0,99)-1, priority just below hearts; seconds<=0 draws nothing.
REQ-026 SHALL, without RENDERER_SECONDS_BAR_EN, omit the bar logic entirely; seconds input unused.

Verification
REQ-027 SHALL cover: reset release, run 420000 cycles -> hsync period 800, low 96 cycles; vsync period 420000, low 1600 cycles; frame_start once per frame.
REQ-028 SHALL cover: background all 1, sprites at 1000 -> every active pixel 0x5AF, blanking 0x000, rgb 2 cycles after counter.
REQ-029 SHALL cover: mario=(100,200), goomba=(120,210) -> pixel (130,220)=0xE00, (150,245)=0x841, (99,200)=tile colour.
REQ-030 SHALL cover: show_hearts=1, lives=7 -> 5 hearts, pixel (88,8)=0xF00, (108,8)=tile; lives=0 -> no hearts.
REQ-031 SHALL cover: mario_x changed mid-frame -> output unchanged until next frame; reset asserted at v=300 -> outputs per REQ-022 and restart at (0,0).
REQ-032 SHALL cover, with RENDERER_SECONDS_BAR_EN: seconds=10 -> (59,465)=0x0F0, (60,465)=tile; seconds=150 -> bar ends x=593.
